// File: rtl/hash_pkg.sv
// Shared sizing and state encoding for the target-hash table loader and its Compare reader.
package hash_pkg;
    localparam int NUM_HASHES     = 64;
    localparam int HASH_W         = 128;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_HASH = HASH_W / WORD_W;
    localparam int IDX_W          = 7;
    localparam int ADDR_W         = $clog2(NUM_HASHES);
    localparam int WCNT_W         = $clog2(WORDS_PER_HASH);
    localparam int TABLE_W        = NUM_HASHES * HASH_W;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
endpackage

// File: rtl/hash_table_loader_if.sv
// Word stream from the hash source into the table loader (valid/ready handshake).
interface hash_table_loader_if;
    import hash_pkg::*;

    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_last;
    logic              word_ready;

    modport master (output word_in, output word_valid, output word_last, input word_ready);
    modport slave  (input word_in, input word_valid, input word_last, output word_ready);
endinterface

// File: rtl/hash_word_assembler.sv
// Collects WORDS_PER_HASH input words, most-significant first, into one hash entry.
module hash_word_assembler
    import hash_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              xfer,
    input  logic [WORD_W-1:0] word_in,
    output logic [WCNT_W-1:0] word_cnt,
    output logic [HASH_W-1:0] hash_out,
    output logic              commit
);
    logic [HASH_W-WORD_W-1:0] asm_buf;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_cnt <= '0;
        end else if (xfer) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    // Data buffer needs no reset: word_cnt alone decides when its contents are used.
    always_ff @(posedge clk) begin
        if (xfer) begin
            asm_buf <= {asm_buf[HASH_W-2*WORD_W-1:0], word_in};
        end
    end

    assign hash_out = {asm_buf, word_in};
    assign commit   = xfer && (word_cnt == WCNT_W'(WORDS_PER_HASH - 1));
endmodule

// File: rtl/hash_table_loader.sv
// Loads up to NUM_HASHES target hashes from a word stream and presents them as a flat table bus.
module hash_table_loader
    import hash_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    hash_table_loader_if.slave   bus,
    output logic [0:TABLE_W-1]   hash_table,
    output logic [IDX_W-1:0]     num_hashes,
    output logic                 table_ready,
    output logic                 err_partial
);
    loader_state_t     state;
    logic              word_ready_q;
    logic              xfer;
    logic              commit;
    logic [WCNT_W-1:0] word_cnt;
    logic [HASH_W-1:0] hash_out;
    logic [HASH_W-1:0] bank [NUM_HASHES];

    assign bus.word_ready = word_ready_q;
    // A new load wins over a word arriving in the same cycle; that word is dropped.
    assign xfer = bus.word_valid && word_ready_q && !load_start;

    hash_word_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clear    (load_start),
        .xfer     (xfer),
        .word_in  (bus.word_in),
        .word_cnt (word_cnt),
        .hash_out (hash_out),
        .commit   (commit)
    );

    always_ff @(posedge clk) begin
        if (rst || load_start) begin
            state        <= rst ? IDLE : LOAD;
            word_ready_q <= !rst;
            num_hashes   <= '0;
            table_ready  <= 1'b0;
            err_partial  <= 1'b0;
            for (int i = 0; i < NUM_HASHES; i++) begin
                bank[i] <= '0;
            end
        end else if (state == LOAD && xfer) begin
            if (commit) begin
                bank[num_hashes[ADDR_W-1:0]] <= hash_out;
                num_hashes <= num_hashes + 1'b1;
                if (num_hashes == IDX_W'(NUM_HASHES - 1) || bus.word_last) begin
                    state        <= DONE;
                    word_ready_q <= 1'b0;
                    table_ready  <= 1'b1;
                end
            end else if (bus.word_last) begin
                state        <= DONE;
                word_ready_q <= 1'b0;
                table_ready  <= 1'b1;
                err_partial  <= 1'b1;
            end
        end
    end

    // Entry i sits at ascending bits [i*HASH_W +: HASH_W], word 0 at the low index.
    for (genvar g = 0; g < NUM_HASHES; g++) begin : g_flat
        assign hash_table[g*HASH_W +: HASH_W] = bank[g];
    end
endmodule
